// File: rtl/transmissor_display_spi.sv
// SSD1306 SPI streamer: display reset pulse, power-up wait, fixed init
// sequence, then one address window plus 1024 framebuffer bytes per refresh.
module transmissor_display_spi #(
    parameter int CLK_DIV        = 2,
    parameter int RESET_CYCLES   = 1000,
    parameter int POWERUP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8191:0] imagem,
    input  logic        atualizar,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        dc,
    output logic        res_n,
    output logic        pronto,
    output logic        ocupado,
    output logic        frame_done
);

    localparam int DMAX = (RESET_CYCLES > POWERUP_CYCLES) ? RESET_CYCLES : POWERUP_CYCLES;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int DIVW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]   RST_LAST = DW'(RESET_CYCLES - 1);
    localparam logic [DW-1:0]   PWR_LAST = DW'(POWERUP_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    typedef enum logic [2:0] {RST_DISP, POWERUP, INIT, IDLE, ADDR, DATA, DONE} state_t;

    state_t          state;
    logic [DW-1:0]   dly;
    logic [4:0]      idx;
    logic [9:0]      bidx;
    logic [9:0]      bidx_nxt;
    logic [DIVW-1:0] div;
    logic            phase;
    logic [2:0]      bitcnt;
    logic [7:0]      sh;
    logic [7:0]      nxt_byte;
    logic            pending;
    logic            sending;
    logic            half_end;
    logic            byte_end;
    logic            load;

    function automatic logic [7:0] init_rom(input logic [4:0] i);
        case (i)
            5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;
            5'd3:  return 8'hA8;  5'd4:  return 8'h3F;  5'd5:  return 8'hD3;
            5'd6:  return 8'h00;  5'd7:  return 8'h40;  5'd8:  return 8'h8D;
            5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h00;
            5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;
            5'd15: return 8'h12;  5'd16: return 8'h81;  5'd17: return 8'hCF;
            5'd18: return 8'hD9;  5'd19: return 8'hF1;  5'd20: return 8'hDB;
            5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
            5'd24: return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] addr_rom(input logic [2:0] i);
        case (i)
            3'd0: return 8'h21;  3'd1: return 8'h00;  3'd2: return 8'h7F;
            3'd3: return 8'h22;  3'd4: return 8'h00;  3'd5: return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    assign sending  = (state == INIT) || (state == ADDR) || (state == DATA);
    assign half_end = (div == DIV_LAST);
    assign byte_end = sending && half_end && phase && (bitcnt == 3'd7);
    assign bidx_nxt = bidx + 10'd1;

    // Byte to be loaded at the next byte start; framebuffer read live, no snapshot
    always_comb begin
        nxt_byte = '0;
        case (state)
            POWERUP: nxt_byte = init_rom(5'd0);
            INIT:    nxt_byte = init_rom(idx + 5'd1);
            IDLE:    nxt_byte = addr_rom(3'd0);
            ADDR:    nxt_byte = (idx == 5'd5) ? imagem[7:0] : addr_rom(idx[2:0] + 3'd1);
            DATA:    nxt_byte = imagem[{bidx_nxt, 3'b000} +: 8];
            default: nxt_byte = '0;
        endcase
    end

    // A new byte starts on entry to a send block or back-to-back at a byte boundary
    always_comb begin
        load = 1'b0;
        if (state == POWERUP && dly == PWR_LAST)
            load = 1'b1;
        else if (state == IDLE && (atualizar || pending))
            load = 1'b1;
        else if (byte_end && ((state == INIT && idx != 5'd24) || state == ADDR ||
                              (state == DATA && bidx != 10'd1023)))
            load = 1'b1;
    end

    // Sequencer FSM with the SPI bit engine and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RST_DISP;
            dly        <= '0;
            idx        <= '0;
            bidx       <= '0;
            div        <= '0;
            phase      <= 1'b0;
            bitcnt     <= '0;
            sh         <= '0;
            pending    <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            dc         <= 1'b0;
            res_n      <= 1'b0;
            pronto     <= 1'b0;
            ocupado    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (atualizar && state != IDLE)
                pending <= 1'b1;

            if (sending && !byte_end) begin
                if (half_end) begin
                    div   <= '0;
                    phase <= ~phase;
                    if (!phase) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk   <= 1'b0;
                        bitcnt <= bitcnt + 3'd1;
                        sh     <= {sh[6:0], 1'b0};
                        mosi   <= sh[6];
                    end
                end else begin
                    div <= div + DIVW'(1);
                end
            end

            if (load) begin
                div    <= '0;
                phase  <= 1'b0;
                bitcnt <= '0;
                sclk   <= 1'b0;
                sh     <= nxt_byte;
                mosi   <= nxt_byte[7];
            end

            case (state)
                RST_DISP: begin
                    if (dly == RST_LAST) begin
                        dly   <= '0;
                        res_n <= 1'b1;
                        state <= POWERUP;
                    end else begin
                        dly <= dly + DW'(1);
                    end
                end
                POWERUP: begin
                    if (dly == PWR_LAST) begin
                        dly   <= '0;
                        idx   <= '0;
                        cs_n  <= 1'b0;
                        dc    <= 1'b0;
                        state <= INIT;
                    end else begin
                        dly <= dly + DW'(1);
                    end
                end
                INIT: begin
                    if (byte_end) begin
                        if (idx == 5'd24) begin
                            cs_n    <= 1'b1;
                            sclk    <= 1'b0;
                            mosi    <= 1'b0;
                            pronto  <= 1'b1;
                            ocupado <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                IDLE: begin
                    if (atualizar || pending) begin
                        idx     <= '0;
                        cs_n    <= 1'b0;
                        dc      <= 1'b0;
                        ocupado <= 1'b1;
                        pending <= 1'b0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (byte_end) begin
                        if (idx == 5'd5) begin
                            bidx  <= '0;
                            dc    <= 1'b1;
                            state <= DATA;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (byte_end) begin
                        if (bidx == 10'd1023) begin
                            cs_n       <= 1'b1;
                            sclk       <= 1'b0;
                            mosi       <= 1'b0;
                            dc         <= 1'b0;
                            frame_done <= 1'b1;
                            ocupado    <= 1'b0;
                            state      <= DONE;
                        end else begin
                            bidx <= bidx_nxt;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= RST_DISP;
            endcase
        end
    end

endmodule

// File: doc/transmissor_display_spi.md
Name: transmissor_display_spi

Overview:
- Downstream stage of controlador_imagens: streams its 1024-byte framebuffer `imagem` to an SSD1306 128x64 OLED over 4-wire SPI, mode 0.
- On power-up it pulses the display's reset pin and sends a fixed initialisation sequence.
- On each refresh request it sends the address window, then the 1024 data bytes, then reports frame completion.

Parameters:
- CLK_DIV, 2: system cycles per SCLK half-period (>=1).
- RESET_CYCLES, 1000: cycles res_n is held low after reset.
- POWERUP_CYCLES, 1000: cycles waited after res_n rises, before init starts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imagem  in  8192  framebuffer; byte i = imagem[i*8 +: 8], i=0..1023.
- atualizar  in  1  one-cycle refresh request.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data, MSB first.
- cs_n  out  1  display chip select, active-low.
- dc  out  1  0 = command byte, 1 = data byte.
- res_n  out  1  display hardware reset, active-low.
- pronto  out  1  init sequence complete.
- ocupado  out  1  reset/init/frame in progress.
- frame_done  out  1  one-cycle pulse after the last data byte.

Behaviour:
- Reset (rst_n=0 at a clk edge), values on the following cycle:
  - cs_n=1, sclk=0, mosi=0, dc=0, res_n=0, pronto=0, ocupado=1, frame_done=0.
  - Pending flag cleared; FSM forced to RST_DISP.
- Reset mid-operation aborts the current byte immediately. No partial-byte completion. The full reset/init sequence is redone.
- FSM states: RST_DISP, POWERUP, INIT, IDLE, ADDR, DATA, DONE.
  - RST_DISP: res_n=0 for RESET_CYCLES cycles, then res_n=1 -> POWERUP.
  - POWERUP: wait POWERUP_CYCLES -> INIT.
  - INIT: send 25 command bytes (dc=0), in order:
    AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
    Then pronto=1 (stays 1 until reset), ocupado=0 -> IDLE.
  - IDLE: if atualizar or pending flag set -> ADDR, ocupado=1, pending cleared.
  - ADDR: send 6 command bytes 21 00 7F 22 00 07 (dc=0) -> DATA.
  - DATA: send bytes i=0..1023 (dc=1). Each byte is read from imagem when its first bit is loaded; no snapshot is taken. imagem must stay stable for the frame, otherwise tearing is permitted.
  - After byte 1023 -> DONE.
  - DONE: cs_n=1, frame_done=1 for exactly one cycle, ocupado=0 -> IDLE.
- atualizar handling:
  - atualizar while ocupado=1 (including before pronto) sets the single pending flag.
  - Multiple requests collapse to one extra frame.
  - atualizar in the same cycle as DONE sets pending; the next frame then starts from IDLE one cycle later.
- Byte framing:
  - cs_n falls on entry to INIT/ADDR and stays low, contiguously, through the whole INIT block or the whole ADDR+DATA block.
  - Each byte is exactly 16*CLK_DIV cycles. Bytes are sent back-to-back with no gap.
  - dc changes only at byte boundaries, while sclk=0.
  - Bit b (7 down to 0) is placed on mosi at the start of its bit slot with sclk=0.
  - sclk rises after CLK_DIV cycles and falls after another CLK_DIV cycles.
  - mosi is stable across each sclk rising edge.
  - sclk=0 whenever cs_n=1.
- Counters:
  - Byte index: 10 bits, no wrap beyond 1023.
  - Init index: 5 bits.
  - Delay counter: sized for max(RESET_CYCLES, POWERUP_CYCLES).
- Frame latency: atualizar in IDLE -> first sclk rise = 1 + CLK_DIV cycles. Frame length = 1030*16*CLK_DIV cycles + 1 DONE cycle.

Test Plan:
- Power-up, CLK_DIV=1, RESET_CYCLES=10, POWERUP_CYCLES=5: release rst_n. Required: res_n low 10 cycles, 5 idle cycles, then an SPI monitor captures exactly the 25 init bytes with dc=0, cs_n low throughout. pronto=1 and ocupado=0 after the last byte.
- Frame: imagem byte i = i[7:0]; pulse atualizar in IDLE. Required: captured 21 00 7F 22 00 07 (dc=0), then 1024 bytes 00..FF repeating 4 times (dc=1). frame_done high exactly 1 cycle, 16*1030 cycles after the first sclk rise region; cs_n=1 afterwards.
- Pulse atualizar 3 times during a frame. Required: exactly one additional complete frame, then IDLE with ocupado=0.
- Pulse atualizar during POWERUP. Required: after init completes, one frame starts without a new request.
- Assert rst_n=0 during data byte 500. Required: next cycle cs_n=1, sclk=0, res_n=0, pronto=0, frame_done never pulses. After release, the full 25-byte init is resent.
- CLK_DIV=3, imagem byte 0 = A5. Required: each sclk half-period is 3 cycles, bits 1,0,1,0,0,1,0,1 are sampled on rising edges, and mosi is stable across each rising edge.
